uart_tx: RTL and testbench

//  Serial transmitter, one frame per request: start bit, DATA_BITS data bits LSB first, stop bit.

---
 rtl/uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Serial transmitter that sends one frame per accepted request. A frame is a
//   start bit, then DATA_BITS data bits LSB first, then a stop bit. The line
//   polarity is inverted for an external inverting driver: idle 0, start 1,
//   data bits complemented, stop 0.
//
//   All state runs on ref_clk. bit_clk is a slower square wave that is
//   synchronous to ref_clk; one bit_clk period is one bit time. Its rising
//   edge is detected in the ref_clk domain, so out and busy change exactly one
//   ref_clk after each bit_clk rising edge.
//
// Parameters
//   DATA_BITS  data bits per frame (width of in)
//
// Ports
//   ref_clk  in   1          system clock, all state on the rising edge
//   reset    in   1          asynchronous, active-high reset (aborts a frame)
//   bit_clk  in   1          bit-rate square wave, rising edge = bit boundary
//   send     in   1          level request, sampled only while busy=0
//   in       in   DATA_BITS  byte to send, captured on acceptance
//   busy     out  1          high from acceptance until the frame ends
//   out      out  1          serial line, inverted polarity (idle 0)
//
// Build option
//   UART_TX_PARITY_EN  when defined, an even-parity bit follows the last data
//                      bit, transmitted inverted like the data (out = ~^data).
//                      Undefined by default: frame is DATA_BITS+2 bits.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    input  logic                 bit_clk,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] in,
    output logic                 busy,
    output logic                 out
);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif
    // Counts bits launched in the current frame, up to FRAME_BITS.
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 out_next, busy_next;
    logic                 bit_clk_q;
    logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_next;
`endif

    // One-cycle pulse in the ref_clk cycle following a bit_clk rising edge.
    assign bit_tick = bit_clk & ~bit_clk_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            // NOTE: the shift register is reset too; it is a handful of flops,
            // and a defined value keeps the datapath X-free after reset.
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            out       <= 1'b0;
            busy      <= 1'b0;
            bit_clk_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            shreg     <= shreg_next;
            out       <= out_next;
            busy      <= busy_next;
            bit_clk_q <= bit_clk;
`ifdef UART_TX_PARITY_EN
            par       <= par_next;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case below can leave a value unassigned (no latches).
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        out_next   = out;
        busy_next  = busy;
`ifdef UART_TX_PARITY_EN
        par_next   = par;
`endif

        case (state)
            IDLE: begin
                out_next  = 1'b0;
                busy_next = 1'b0;
                if (send) begin
                    shreg_next = in;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = WAIT;
`ifdef UART_TX_PARITY_EN
                    par_next   = ^in;
`endif
                end
            end

            // Start bit is launched on a tick so it always spans a full bit.
            WAIT: begin
                if (bit_tick) begin
                    out_next   = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = DATA;
                end
            end

            // cnt holds the number of bits already launched, so the tick
            // seen with cnt == DATA_BITS launches the last data bit.
            DATA: begin
                if (bit_tick) begin
                    out_next   = ~shreg[0];
                    shreg_next = shreg >> 1;
                    cnt_next   = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    out_next   = ~par;
                    cnt_next   = cnt + CNT_W'(1);
                    state_next = STOP;
                end
            end
`endif

            // First tick launches the stop bit; the next tick ends the frame,
            // so busy only drops once the stop bit has lasted a full period.
            STOP: begin
                if (bit_tick) begin
                    out_next = 1'b0;
                    if (cnt == CNT_W'(FRAME_BITS - 1)) begin
                        cnt_next = cnt + CNT_W'(1);
                    end else begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                out_next   = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Self-checking bench for uart_tx. A line monitor samples out on every
//   bit_clk rising edge, decodes frames (start 1, complemented data LSB first,
//   optional parity, stop 0, then at least one idle bit) and compares each
//   decoded frame with the expected entry queued when the request was driven.
//   Table-driven frames cover single and back-to-back transfers and an input
//   that goes X after acceptance; hand-written sequences cover reset state,
//   idle behaviour and a reset that aborts a frame mid data bit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif
    // bit_clk rises from request to busy falling: one to launch each frame
    // bit plus one more to end the stop bit.
    localparam int EXP_RISES  = FRAME_BITS + 1;
    localparam int BUSY_LIMIT = 400;
    localparam int NUM_VECS   = 7;

    logic                 ref_clk = 1'b0;
    logic                 reset   = 1'b1;
    logic                 bit_clk = 1'b0;
    logic                 send    = 1'b0;
    logic [DATA_BITS-1:0] in      = '0;
    logic                 busy;
    logic                 out;

    int checks_total  = 0;
    int checks_passed = 0;
    int rise_cnt      = 0;
    int frames_done   = 0;
    int exp_frames    = 0;
    int div           = 0;
    bit mon_en        = 1'b1;

    typedef struct {
        logic [DATA_BITS-1:0] line;      // expected data bits as seen on the line
        logic                 par_line;  // expected parity bit as seen on the line
    } exp_t;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic [DATA_BITS-1:0] line;
        bit                   keep_send;  // hold send high into the next frame
        bit                   x_after;    // drive in to X once busy rises
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[NUM_VECS];

    uart_tx #(.DATA_BITS(DATA_BITS)) dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bit_clk (bit_clk),
        .send    (send),
        .in      (in),
        .busy    (busy),
        .out     (out)
    );

    always #5 ref_clk = ~ref_clk;

    // bit_clk: 8 ref_clk periods per bit, changing just after ref_clk rises.
    always @(posedge ref_clk) begin
        if (div == 3) begin
            div     <= 0;
            bit_clk <= ~bit_clk;
        end else begin
            div <= div + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at a ref_clk falling edge; bounded so a stuck DUT still ends.
    task automatic wait_busy(input logic val, input string name);
        int n = 0;
        while (busy !== val && n < BUSY_LIMIT) begin
            @(negedge ref_clk);
            n++;
        end
        check(name, busy, val);
    endtask

    // Line monitor / scoreboard consumer.
    int                   mon_phase = 0;
    int                   mon_k     = 0;
    logic [DATA_BITS-1:0] mon_line  = '0;
    logic                 mon_par   = 1'b0;
    exp_t                 mon_exp;

    always @(posedge bit_clk) begin
        rise_cnt++;
        #1;
        if (!mon_en) begin
            mon_phase = 0;
        end else begin
            case (mon_phase)
                0: begin
                    if (out === 1'b1) begin
                        mon_phase = 1;
                        mon_k     = 0;
                    end
                end
                1: begin
                    mon_line[mon_k] = out;
                    mon_k++;
                    if (mon_k == DATA_BITS) begin
`ifdef UART_TX_PARITY_EN
                        mon_phase = 2;
`else
                        mon_phase = 3;
`endif
                    end
                end
                2: begin
                    mon_par   = out;
                    mon_phase = 3;
                end
                3: begin
                    check("stop_bit", out, 1'b0);
                    check("busy_during_stop", busy, 1'b1);
                    check("sb_has_entry", sb_q.size() > 0, 1'b1);
                    if (sb_q.size() > 0) begin
                        mon_exp = sb_q.pop_front();
                        check("frame_data", mon_line, mon_exp.line);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", mon_par, mon_exp.par_line);
`endif
                    end
                    frames_done++;
                    mon_phase = 4;
                end
                default: begin
                    check("gap_idle", out, 1'b0);
                    mon_phase = 0;
                end
            endcase
        end
    end

    // Drives one request from a ref_clk falling edge and returns at the
    // falling edge after busy drops.
    task automatic send_frame(input logic [DATA_BITS-1:0] data,
                              input logic [DATA_BITS-1:0] line,
                              input bit keep_send, input bit x_after);
        int start_rises;
        sb_q.push_back('{line: line, par_line: ~(^data)});
        exp_frames++;
        in          = data;
        send        = 1'b1;
        start_rises = rise_cnt;
        @(posedge ref_clk);
        #1;
        check("busy_rise", busy, 1'b1);
        if (!keep_send) send = 1'b0;
        if (x_after) in = 'x;
        @(negedge ref_clk);
        wait_busy(1'b0, "busy_fall");
        check("stop_before_busy_fall", frames_done, exp_frames);
        check("frame_len", rise_cnt - start_rises, EXP_RISES);
        check("line_idle_after_frame", out, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'hA9, 8'h56, 1'b0, 1'b0};
        vecs[1] = '{8'hCA, 8'h35, 1'b1, 1'b0};
        vecs[2] = '{8'hA1, 8'h5E, 1'b1, 1'b0};
        vecs[3] = '{8'hB2, 8'h4D, 1'b1, 1'b0};
        vecs[4] = '{8'hC3, 8'h3C, 1'b1, 1'b0};
        vecs[5] = '{8'h4B, 8'hB4, 1'b0, 1'b0};
        vecs[6] = '{8'h3C, 8'hC3, 1'b0, 1'b1};

        // Reset state.
        repeat (3) @(negedge ref_clk);
        check("reset_busy", busy, 1'b0);
        check("reset_out", out, 1'b0);
        reset = 1'b0;

        // Idle with send low for three bit periods.
        in = 8'hA9;
        repeat (3) begin
            @(posedge bit_clk);
            #1;
            check("idle_busy", busy, 1'b0);
            check("idle_out", out, 1'b0);
        end
        @(negedge ref_clk);

        // Single, back-to-back and X-after-acceptance frames.
        for (int i = 0; i < NUM_VECS; i++) begin
            send_frame(vecs[i].data, vecs[i].line, vecs[i].keep_send, vecs[i].x_after);
        end
        in = '0;
        repeat (2) @(posedge bit_clk);
        @(negedge ref_clk);

        // Reset in the middle of a data bit aborts the frame.
        mon_en = 1'b0;
        in     = 8'h00;
        send   = 1'b1;
        @(posedge ref_clk);
        #1;
        check("abort_busy_rise", busy, 1'b1);
        send = 1'b0;
        repeat (4) @(posedge bit_clk);
        repeat (3) @(negedge ref_clk);
        check("abort_line_active", out, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("abort_out", out, 1'b0);
        check("abort_busy", busy, 1'b0);
        @(negedge ref_clk);
        reset = 1'b0;
        repeat (2) begin
            @(posedge bit_clk);
            #1;
            check("no_resume_out", out, 1'b0);
            check("no_resume_busy", busy, 1'b0);
        end
        @(negedge ref_clk);
        mon_en = 1'b1;
        send_frame(8'h55, 8'hAA, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
        send_frame(8'h07, 8'hF8, 1'b0, 1'b0);
        check("parity_07", mon_par, 1'b0);
`endif

        repeat (2) @(posedge bit_clk);
        #2;
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
